exc_sequencer: RTL and testbench
================================

# exc_sequencer

Trap-entry/exit sequencer that sits between the pipeline's decode/execute stage and the CP0 register file. It arbitrates syscall, break, teq and (optionally) external-interrupt requests against the CP0 Status masks. For each accepted event it runs a fixed multi-cycle sequence: stall the pipeline, drive the CP0 exception/eret strobes with cause and EPC, then redirect the PC. It also tracks nesting depth so Status shifting never overruns.

## Interface
- HANDLER_ADDR, 32'h00400004, PC loaded on trap entry
- MAX_DEPTH, 3, maximum nested trap depth (1..6)
- clk_sig  in  1  clock, rising edge
- rst_n_sig  in  1  reset, asynchronous, active-low
- syscall_req  in  1  single-cycle request from the current instruction
- break_req  in  1  single-cycle request
- teq_req  in  1  single-cycle request (teq condition already true)
- int_req  in  1  external interrupt, level
- eret_req  in  1  single-cycle eret request
- inst_pc  in  32  PC of the requesting instruction (next PC for interrupts)
- status_in  in  32  CP0 Status value
- epc_in  in  32  CP0 return address, valid while eret_flag=1
- stall  out  1  freeze fetch/decode
- exc_flag  out  1  CP0 exception strobe
- eret_flag  out  1  CP0 eret strobe
- cause_val  out  5  exception code
- pc_val  out  32  EPC to CP0
- pc_redirect  out  1  load redirect_addr into PC
- redirect_addr  out  32  new PC
- depth  out  3  current nesting depth

## Operation
- States: IDLE, ENTER, VECTOR, RETURN.
- Acceptance in IDLE only. Global enable is status_in[0]. Per-source enables: syscall status_in[1], break [2], teq [3], interrupt [4].
- A source is accepted when its request is high, its enable and global enable are 1, and depth < MAX_DEPTH.
- Priority: teq (cause 13) > break (9) > syscall (8) > interrupt (0).
- Masked or over-depth sync requests are dropped. No latching.
- int_req is level. It stays pending naturally and is re-evaluated every IDLE cycle.
- Exception accepted in IDLE: latch cause and inst_pc, go to ENTER.
  - ENTER: exc_flag=1, cause_val/pc_val valid, depth++, go to VECTOR.
  - VECTOR: pc_redirect=1, redirect_addr=HANDLER_ADDR, go to IDLE.
- eret_req in IDLE with no accepted exception, and depth>0: go to RETURN.
  - RETURN: eret_flag=1, pc_redirect=1, redirect_addr=epc_in (CP0 supplies it combinationally), depth--, go to IDLE.
- eret_req at depth 0 is ignored.
- eret_req together with an accepted exception: the exception wins and the eret is dropped.
- Requests arriving outside IDLE are ignored. The pipeline is stalled, so none are legal.

## Timing
- Reset values: state IDLE, depth 0, cause/pc latches 0, and every output 0, including redirect_addr.
- stall=1 in ENTER, VECTOR and RETURN. stall=0 in IDLE (combinational from state).
- Exception accepted at edge N (sampled in IDLE):
  - cycle N+1: ENTER, exc_flag=1.
  - cycle N+2: VECTOR, pc_redirect=1.
  - cycle N+3: IDLE.
  - Trap latency: 2 cycles from sampling to redirect.
- eret sampled at edge N: cycle N+1 is RETURN with eret_flag and pc_redirect; IDLE at N+2.
- exc_flag, eret_flag and pc_redirect are each exactly one cycle wide and never overlap.
- CP0 shifts Status at the end of ENTER. The next IDLE acceptance uses the shifted value.
- depth updates on the edge leaving ENTER/RETURN. It saturates at MAX_DEPTH and at 0.
- Reset asserted mid-sequence forces IDLE immediately (async). Strobes drop the same cycle.

## Configuration
- EXC_INT_EN defined: int_req participates in arbitration as described.
- EXC_INT_EN undefined:
  - int_req is ignored.
  - Interrupt logic is compiled out.
  - status_in[4] is unused.
  - Cause 0 is never generated.

## Test plan
- Reset: rst_n_sig=0 mid-ENTER -> all outputs 0, state IDLE, depth 0. Release with no request -> stall stays 0.
- Syscall: status_in=32'h3, syscall_req pulse, inst_pc=32'h00400020.
  - Next cycle: exc_flag=1, cause_val=8, pc_val=32'h00400020, stall=1.
  - Following cycle: pc_redirect=1, redirect_addr=32'h00400004.
  - Then: depth=1.
- Priority: teq_req, break_req and int_req all high, status_in=32'h1F -> cause_val=13 only. int_req still high afterward -> taken later only if shifted Status bits 0 and 4 are 1.
- Mask and depth:
  - break_req with status_in[2]=0 -> no strobe, stall stays 0.
  - With depth=MAX_DEPTH, any request -> dropped.
- Eret:
  - At depth 1, eret_req, epc_in=32'h00400020 -> eret_flag=1, pc_redirect=1, redirect_addr=32'h00400020, then depth=0.
  - A second eret -> ignored.
- Simultaneous: syscall_req and eret_req together at depth 1 -> exception sequence runs, no eret_flag, depth=2.

Source files
------------

// File: rtl/exc_sequencer.sv
// exc_sequencer: trap entry/exit sequencer between decode/execute and CP0 with nesting depth tracking.
// Optional external-interrupt arbitration is enabled by defining EXC_INT_EN.
module exc_sequencer #(
  parameter logic [31:0] HANDLER_ADDR = 32'h00400004,
  parameter int MAX_DEPTH = 3
) (
  input  logic        clk_sig,
  input  logic        rst_n_sig,
  input  logic        syscall_req,
  input  logic        break_req,
  input  logic        teq_req,
  input  logic        int_req,
  input  logic        eret_req,
  input  logic [31:0] inst_pc,
  input  logic [31:0] status_in,
  input  logic [31:0] epc_in,
  output logic        stall,
  output logic        exc_flag,
  output logic        eret_flag,
  output logic [4:0]  cause_val,
  output logic [31:0] pc_val,
  output logic        pc_redirect,
  output logic [31:0] redirect_addr,
  output logic [2:0]  depth
);
  typedef enum logic [1:0] {IDLE, ENTER, VECTOR, RETURN} state_t;
  localparam logic [2:0] MAX_D = 3'(MAX_DEPTH);
  state_t state;
  logic teq_ok, brk_ok, sys_ok, int_ok, accept, take_eret, unused_bits;
  logic [4:0] cause_next;
`ifdef EXC_INT_EN
  assign int_ok = int_req & status_in[4];
  assign unused_bits = ^status_in[31:5];
`else
  assign int_ok = 1'b0;
  assign unused_bits = ^{int_req, status_in[31:4]};
`endif
  assign teq_ok = teq_req & status_in[3];
  assign brk_ok = break_req & status_in[2];
  assign sys_ok = syscall_req & status_in[1];
  assign accept = status_in[0] & (depth < MAX_D) & (teq_ok | brk_ok | sys_ok | int_ok);
  assign cause_next = teq_ok ? 5'd13 : brk_ok ? 5'd9 : sys_ok ? 5'd8 : 5'd0;
  // an exception accepted in the same cycle swallows the eret
  assign take_eret = eret_req & (depth != 3'd0) & ~accept;
  always_ff @(posedge clk_sig or negedge rst_n_sig) begin
    if (!rst_n_sig) begin
      state <= IDLE;
      depth <= 3'd0;
      cause_val <= 5'd0;
      pc_val <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= ENTER;
            cause_val <= cause_next;
            pc_val <= inst_pc;
          end else if (take_eret) state <= RETURN;
        end
        ENTER: begin
          state <= VECTOR;
          if (depth < MAX_D) depth <= depth + 3'd1;
        end
        VECTOR: state <= IDLE;
        default: begin
          state <= IDLE;
          if (depth != 3'd0) depth <= depth - 3'd1;
        end
      endcase
    end
  end
  assign stall = state != IDLE;
  assign exc_flag = state == ENTER;
  assign eret_flag = state == RETURN;
  assign pc_redirect = (state == VECTOR) | (state == RETURN);
  assign redirect_addr = state == VECTOR ? HANDLER_ADDR : state == RETURN ? epc_in : 32'd0;
endmodule

// File: tb/tb_exc_sequencer.sv
// tb_exc_sequencer: directed plus randomized checking of exc_sequencer against a phase-queue model.
module tb_exc_sequencer;
  localparam logic [31:0] HANDLER = 32'h00400004;
  localparam int MAXD = 3;
  logic clk_sig = 0, rst_n_sig = 0;
  logic syscall_req = 0, break_req = 0, teq_req = 0, int_req = 0, eret_req = 0;
  logic [31:0] inst_pc = 0, status_in = 0, epc_in = 0;
  logic stall, exc_flag, eret_flag, pc_redirect;
  logic [4:0] cause_val;
  logic [31:0] pc_val, redirect_addr;
  logic [2:0] depth;
  int errors = 0, checks = 0;
  // model: queue of upcoming non-idle cycles (1 trap strobe, 2 handler jump, 3 return)
  int q[$];
  int md = 0;
  logic [4:0] mcause = 0;
  logic [31:0] mpc = 0;

  exc_sequencer #(.HANDLER_ADDR(HANDLER), .MAX_DEPTH(MAXD)) dut (
    .clk_sig(clk_sig), .rst_n_sig(rst_n_sig), .syscall_req(syscall_req), .break_req(break_req),
    .teq_req(teq_req), .int_req(int_req), .eret_req(eret_req), .inst_pc(inst_pc),
    .status_in(status_in), .epc_in(epc_in), .stall(stall), .exc_flag(exc_flag),
    .eret_flag(eret_flag), .cause_val(cause_val), .pc_val(pc_val), .pc_redirect(pc_redirect),
    .redirect_addr(redirect_addr), .depth(depth));

  always #5 clk_sig = ~clk_sig;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    int cur;
    cur = q.size() != 0 ? q[0] : 0;
    chk("stall", 32'(stall), 32'(cur != 0));
    chk("exc_flag", 32'(exc_flag), 32'(cur == 1));
    chk("eret_flag", 32'(eret_flag), 32'(cur == 3));
    chk("pc_redirect", 32'(pc_redirect), 32'(cur == 2 || cur == 3));
    chk("redirect_addr", redirect_addr, cur == 2 ? HANDLER : cur == 3 ? epc_in : 32'd0);
    chk("depth", 32'(depth), 32'(md));
    if (cur == 1) begin
      chk("cause_val", 32'(cause_val), 32'(mcause));
      chk("pc_val", pc_val, mpc);
    end
  endtask

  task automatic model_step();
    logic en;
    int c;
    if (q.size() != 0) begin
      if (q[0] == 1 && md < MAXD) md++;
      if (q[0] == 3 && md > 0) md--;
      void'(q.pop_front());
    end else begin
      en = status_in[0] && md < MAXD;
      c = -1;
      if (en && teq_req && status_in[3]) c = 13;
      else if (en && break_req && status_in[2]) c = 9;
      else if (en && syscall_req && status_in[1]) c = 8;
`ifdef EXC_INT_EN
      else if (en && int_req && status_in[4]) c = 0;
`endif
      if (c >= 0) begin
        q.push_back(1);
        q.push_back(2);
        mcause = 5'(c);
        mpc = inst_pc;
      end else if (eret_req && md > 0) q.push_back(3);
    end
  endtask

  // called at a negedge: drive inputs, advance model over the coming edge, check after it
  task automatic tick(input logic s, b, t, i, e, input logic [31:0] ipc, st, ep);
    syscall_req = s; break_req = b; teq_req = t; int_req = i; eret_req = e;
    inst_pc = ipc; status_in = st; epc_in = ep;
    model_step();
    @(negedge clk_sig);
    compare();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0, inst_pc, status_in, epc_in);
  endtask

  task automatic do_reset();
    rst_n_sig = 0;
    q.delete();
    md = 0;
    @(negedge clk_sig);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_depth", 32'(depth), 0);
    chk("rst_redirect_addr", redirect_addr, 0);
    chk("rst_cause", 32'(cause_val), 0);
    chk("rst_pc_val", pc_val, 0);
    rst_n_sig = 1;
  endtask

  initial begin
    do_reset();
    // syscall trap entry
    tick(1, 0, 0, 0, 0, 32'h00400020, 32'h3, 0);
    chk("sys_exc", 32'(exc_flag), 1);
    chk("sys_cause", 32'(cause_val), 8);
    chk("sys_pc", pc_val, 32'h00400020);
    chk("sys_stall", 32'(stall), 1);
    idle(1);
    chk("sys_redirect", 32'(pc_redirect), 1);
    chk("sys_addr", redirect_addr, 32'h00400004);
    idle(1);
    chk("sys_depth", 32'(depth), 1);
    chk("sys_idle_stall", 32'(stall), 0);
    // eret at depth 1, then a second eret at depth 0
    tick(0, 0, 0, 0, 1, 0, 32'h3, 32'h00400020);
    chk("eret_flag", 32'(eret_flag), 1);
    chk("eret_redirect", 32'(pc_redirect), 1);
    chk("eret_addr", redirect_addr, 32'h00400020);
    idle(1);
    chk("eret_depth", 32'(depth), 0);
    tick(0, 0, 0, 0, 1, 0, 32'h3, 32'h00400020);
    chk("eret2_ignored", 32'(eret_flag), 0);
    chk("eret2_stall", 32'(stall), 0);
    // masked break
    tick(0, 1, 0, 0, 0, 32'h100, 32'h3, 0);
    chk("mask_exc", 32'(exc_flag), 0);
    chk("mask_stall", 32'(stall), 0);
    // priority: teq wins over break and interrupt
    tick(1, 1, 1, 1, 0, 32'h200, 32'h1F, 0);
    chk("prio_cause", 32'(cause_val), 13);
    idle(2);
    // syscall with eret at depth 1: exception wins
    tick(1, 0, 0, 0, 1, 32'h300, 32'h3, 32'h44);
    chk("sim_exc", 32'(exc_flag), 1);
    chk("sim_eret", 32'(eret_flag), 0);
    idle(2);
    chk("sim_depth", 32'(depth), 2);
    // fill to MAX_DEPTH then confirm drop
    tick(1, 0, 0, 0, 0, 32'h400, 32'h3, 0);
    idle(2);
    chk("full_depth", 32'(depth), MAXD);
    tick(1, 1, 1, 1, 0, 32'h500, 32'h1F, 0);
    chk("full_drop", 32'(exc_flag), 0);
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] st;
      st = $urandom;
      if ($urandom_range(0, 3) != 0) st[4:0] = 5'h1F;
      tick($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, $urandom, st, $urandom);
    end
    // reset in the middle of ENTER
    do_reset();
    tick(1, 0, 0, 0, 0, 32'h600, 32'h3, 0);
    chk("pre_rst_exc", 32'(exc_flag), 1);
    rst_n_sig = 0;
    #1;
    chk("mid_rst_exc", 32'(exc_flag), 0);
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_redirect", 32'(pc_redirect), 0);
    chk("mid_rst_depth", 32'(depth), 0);
    chk("mid_rst_cause", 32'(cause_val), 0);
    q.delete();
    md = 0;
    @(negedge clk_sig);
    rst_n_sig = 1;
    idle(2);
    chk("post_rst_stall", 32'(stall), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
